// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues request-to-send,
// shifts a byte plus odd parity out on device-generated clock falls and reports the ACK.
module ps2_host_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int INHIBIT_CYC = (CLK_FREQ / 1000000) * INHIBIT_US;
  localparam int TIMEOUT_CYC = (CLK_FREQ / 1000000) * TIMEOUT_US;
  localparam int MAX_CYC     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [8:0]       shift_q, shift_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_ok_q, ack_ok_d;
  logic             ack_pend_q, ack_pend_d;
  logic             err_q, err_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;

  assign fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    data_oe_d  = data_oe_q;
    ack_pend_d = ack_pend_q;
    ack_ok_d   = ack_ok_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready_q) begin
          shift_d  = {~^tx_data, tx_data};
          bitcnt_d = '0;
          cnt_d    = '0;
          state_d  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          // Clock release and start bit happen on the same edge so both lines are never low together.
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = ST_RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RTS, ST_SHIFT, ST_ACK: begin
        if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_IDLE;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          ack_ok_d  = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (fall) begin
            if (state_q == ST_ACK) begin
              ack_pend_d = ~data_sync_q;
              state_d    = ST_WAIT_IDLE;
            end else if (state_q == ST_SHIFT && bitcnt_q == 4'd9) begin
              data_oe_d = 1'b0;
              state_d   = ST_ACK;
            end else begin
              // shift_q holds data LSB first followed by parity.
              data_oe_d = ~shift_q[0];
              shift_d   = {1'b0, shift_q[8:1]};
              bitcnt_d  = bitcnt_q + 4'd1;
              state_d   = ST_SHIFT;
            end
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          done_d   = 1'b1;
          ack_ok_d = ack_pend_q;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        data_oe_d = 1'b0;
      end
    endcase

    clk_oe_d   = (state_d == ST_INHIBIT);
    busy_d     = (state_d != ST_IDLE);
    tx_ready_d = (state_d == ST_IDLE) && !done_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      tx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_ok_q    <= 1'b0;
      ack_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_ok_q    <= ack_ok_d;
      ack_pend_q  <= ack_pend_d;
      err_q       <= err_d;
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus with a clocking device model, accept-time
// scoreboard of expected frames/ACK results, and a done-driven checking monitor.
module tb_ps2_host_tx;

  localparam int CLK_FREQ    = 1000000;
  localparam int INHIBIT_US  = 100;
  localparam int TIMEOUT_US  = 2000;
  localparam int INHIBIT_CYC = 100;
  localparam int TIMEOUT_CYC = 2000;

  localparam int M_NORMAL = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;

  typedef struct {
    logic [7:0] b;
    logic [9:0] frame;
    logic       ack;
    logic       err;
    logic       chk_frame;
  } exp_t;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, ack_ok, err_timeout;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clock      (clk),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  int         dev_mode        = M_NORMAL;
  logic       dev_active      = 1'b0;
  int         dev_rises       = 0;
  logic [9:0] dev_frame       = '0;
  logic       dev_frame_valid = 1'b0;

  int   cyc           = 0;
  int   done_cnt      = 0;
  int   acc_cnt       = 0;
  int   acc_done_snap = 0;
  int   inh_run       = 0;
  int   inh_len       = 0;
  int   rts_cyc       = 0;
  logic rts_seen      = 1'b0;
  int   overlap       = 0;
  int   ack_viol      = 0;
  logic prev_ack      = 1'b0;
  logic ready_pending = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Reference: frame as the device sees it on its rising edges = data, odd parity, stop.
  function automatic exp_t model(input logic [7:0] b, input int mode);
    exp_t e;
    int   ones;
    ones        = $countones(b);
    e.b         = b;
    e.frame     = 10'(b) + (((ones % 2) == 0) ? 10'd256 : 10'd0) + 10'd512;
    e.ack       = (mode == M_NORMAL);
    e.err       = (mode == M_SILENT);
    e.chk_frame = (mode != M_SILENT);
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Accept monitor: expected response enters the scoreboard at the handshake.
  initial forever begin
    @(posedge clk);
    if (reset_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      exp_q.push_back(model(tx_data, dev_mode));
      acc_cnt++;
      acc_done_snap = done_cnt;
    end
  end

  // Device model: 40-cycle clock after request-to-send, samples data on rising edges.
  initial begin : device
    logic [9:0] bits;
    bits = '0;
    forever begin
      @(negedge clk);
      if (ps2_data_in === 1'b0 && ps2_clk_in === 1'b1) begin
        dev_active = 1'b1;
        dev_rises  = 0;
        if (dev_mode == M_SILENT) begin
          while (ps2_data_in !== 1'b1) @(negedge clk);
        end else begin
          repeat (10) @(negedge clk);
          for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            dev_rises++;
            if (k <= 10) bits[k-1] = ps2_data_in;
            if (k == 10) begin
              dev_frame       = bits;
              dev_frame_valid = 1'b1;
            end
            repeat (10) @(negedge clk);
            if (k == 10 && dev_mode == M_NORMAL) dev_data = 1'b0;
            repeat (10) @(negedge clk);
          end
          dev_data = 1'b1;
        end
        dev_active = 1'b0;
      end
    end
  end

  // Checking monitor: pops one expectation per done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        prev_ack = ack_ok;
        inh_run  = 0;
        continue;
      end
      if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) overlap++;
      if (ps2_clk_oe === 1'b1) inh_run++;
      else if (inh_run > 0) begin
        inh_len  = inh_run;
        inh_run  = 0;
        rts_seen = ps2_data_oe;
        rts_cyc  = cyc;
      end
      if (done !== 1'b1 && ack_ok !== prev_ack) ack_viol++;
      prev_ack = ack_ok;
      if (ready_pending) begin
        check("tx_ready_after_done", tx_ready, 1);
        ready_pending = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("txn byte=%02h ack_ok=%0b err_timeout=%0b frame=%03h", e.b, ack_ok, err_timeout, dev_frame);
          check("ack_ok", ack_ok, e.ack);
          check("err_timeout", err_timeout, e.err);
          check("inhibit_len", inh_len, INHIBIT_CYC);
          check("rts_after_inhibit", rts_seen, 1);
          check("oe_overlap", overlap, 0);
          check("ack_hold", ack_viol, 0);
          check("busy_at_done", busy, 0);
          if (e.chk_frame) begin
            check("frame_valid", dev_frame_valid, 1);
            check("frame", dev_frame, e.frame);
          end
          if (e.err) begin
            check("timeout_latency", cyc - rts_cyc, TIMEOUT_CYC);
            check("clk_oe_at_timeout", ps2_clk_oe, 0);
            check("data_oe_at_timeout", ps2_data_oe, 0);
          end
        end
        overlap         = 0;
        ack_viol        = 0;
        dev_frame_valid = 1'b0;
        ready_pending   = 1'b1;
      end
    end
  end

  task automatic wait_dev_idle();
    int n;
    n = 0;
    while (dev_active && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("device_idle", dev_active, 0);
  endtask

  task automatic send(input logic [7:0] b, input int mode);
    int d0, n;
    dev_mode = mode;
    d0       = done_cnt;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    n = 0;
    while (done_cnt == d0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", done_cnt != d0, 1);
    wait_dev_idle();
    repeat (5) @(negedge clk);
  endtask

  task automatic reset_mid();
    int n, d0;
    dev_mode = M_NORMAL;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (!(dev_active && dev_rises >= 4) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reached_shift", dev_rises >= 4, 1);
    check("data_oe_before_reset", ps2_data_oe, 1);
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_ready", tx_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt;
    wait_dev_idle();
    repeat (50) @(negedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    dev_frame_valid = 1'b0;
  endtask

  task automatic held_valid();
    int a0, d0, n;
    a0       = acc_cnt;
    d0       = done_cnt;
    dev_mode = M_NORMAL;
    @(negedge clk);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    check("held_second_accept_after_done", acc_done_snap, d0 + 1);
    n = 0;
    while (done_cnt < d0 + 2 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    wait_dev_idle();
    repeat (200) @(negedge clk);
    check("held_accept_count", acc_cnt - a0, 2);
    check("held_done_count", done_cnt - d0, 2);
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ack_ok", ack_ok, 0);
    check("reset_err_timeout", err_timeout, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hED, M_NORMAL);
    send(8'h07, M_NORMAL);
    send(8'h00, M_NORMAL);
    send(8'($urandom), M_NOACK);
    send(8'($urandom), M_SILENT);
    reset_mid();
    held_valid();
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NOACK : M_NORMAL);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget, got %0d cycles expected under 80000", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the outgoing counterpart of the existing keyboard receiver.
- Sends single command bytes to the keyboard, such as 0xED (set LEDs) and 0xFF (reset), using the open-collector request-to-send protocol.
- Reports the device ACK. Sits beside the keyboard receiver on the same PS2_CLK/PS2_DATA pins.
- The top level builds the tristate buffers: a pin is driven low when its oe is 1, otherwise high-Z.

Parameters:
- CLK_FREQ, 50000000, frequency of clock in Hz.
- INHIBIT_US, 100, time the clock line is held low before request-to-send, in µs.
- TIMEOUT_US, 15000, maximum time from request-to-send to ACK, in µs.
- Derived values, integer arithmetic:
  - INHIBIT_CYC = (CLK_FREQ/1000000)*INHIBIT_US
  - TIMEOUT_CYC = (CLK_FREQ/1000000)*TIMEOUT_US

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous reset, active-low.
- ps2_clk_in  input  1  raw PS2_CLK pin level (asynchronous).
- ps2_data_in  input  1  raw PS2_DATA pin level (asynchronous).
- ps2_clk_oe  output  1  1 = pull PS2_CLK low.
- ps2_data_oe  output  1  1 = pull PS2_DATA low.
- tx_data  input  8  command byte.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  1 only in IDLE; transfer accepted when tx_valid & tx_ready.
- busy  output  1  1 in every state except IDLE.
- done  output  1  one-cycle pulse at transfer end (success or error).
- ack_ok  output  1  valid when done is 1; 1 = device ACKed.
- err_timeout  output  1  one-cycle pulse, coincident with done, on timeout.

Behaviour:
- Reset (reset_n = 0 at posedge):
  - State IDLE, all counters cleared.
  - ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, busy = 0, done = 0, ack_ok = 0, err_timeout = 0.
  - Reset mid-transfer releases both lines on the next edge and discards the byte.
- Input sync:
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer, plus one history flop on clock.
  - fall = clk_prev & ~clk_sync, i.e. a one-cycle strobe, 3 cycles after the pin edge.
- Latch: on accept, capture the byte and parity = ~^tx_data (odd parity). Clear bitcnt and the cycle counter.
- States:
  - IDLE: both oe = 0. On accept, go to INHIBIT on the next edge.
  - INHIBIT:
    - ps2_clk_oe = 1, ps2_data_oe = 0; counter increments each cycle.
    - When counter == INHIBIT_CYC-1, go to RTS and clear the counter.
  - RTS:
    - ps2_data_oe = 1 (start bit 0), ps2_clk_oe = 0.
    - Timeout counter runs from here until ACK.
    - On fall: drive bit0 (ps2_data_oe = ~bit0), bitcnt = 1, go to SHIFT.
  - SHIFT:
    - On each fall, drive the next bit LSB first: bits 1..7, then parity.
    - Data changes only on fall strobes.
    - After parity is driven (bitcnt = 9), the next fall releases data (stop bit, ps2_data_oe = 0) and goes to ACK.
  - ACK:
    - On the next fall, sample data_sync: ack_ok = ~data_sync (0 on the line means ACK). Go to WAIT_IDLE.
  - WAIT_IDLE:
    - When clk_sync = 1 and data_sync = 1 in the same cycle, pulse done for 1 cycle and go to IDLE.
    - tx_ready = 1 from the cycle after done.
- Timeout:
  - In RTS, SHIFT and ACK, if the counter reaches TIMEOUT_CYC-1, then on the next edge:
    - release both lines;
    - pulse done and err_timeout;
    - ack_ok = 0; go to IDLE.
  - WAIT_IDLE has no timeout; it waits for the bus to go idle.
- Rules:
  - ps2_clk_oe and ps2_data_oe are never both 1 except for zero cycles: INHIBIT releases clock and asserts data on the same edge.
  - tx_valid while busy is ignored (tx_ready = 0); tx_data is used only at accept.
  - ack_ok holds its value until the next done.
  - Falls seen in IDLE or INHIBIT are ignored, e.g. the keyboard is sending scan codes or the line echoes our own inhibit.

Test Plan:
- Setup: CLK_FREQ = 1000000, INHIBIT_US = 100, TIMEOUT_US = 2000. A device model gives a 40-cycle clock period and drives ACK low during fall #11.
- Send 0xED:
  - ps2_clk_oe high for exactly 100 cycles, then data_oe = 1.
  - Line bits after start, LSB first: 1,0,1,1,0,1,1,1; parity 1; stop 1.
  - ACK sampled: done = 1, ack_ok = 1, tx_ready returns 1.
- Send 0x07: line bits 1,1,1,0,0,0,0,0; parity 0. Send 0x00: parity 1. Both end with ack_ok = 1.
- Device model withholds ACK (data stays high at fall #11) -> done = 1, ack_ok = 0, err_timeout = 0.
- Device model never clocks after RTS -> 2000 cycles after RTS entry: err_timeout = done = 1, both oe = 0, state IDLE.
- Reset edge cases:
  - reset_n = 0 during SHIFT after 4 bits -> next cycle both oe = 0, busy = 0, no done pulse.
  - tx_valid held during a transfer -> second byte accepted only after done, and only once per accept.
